memory_port_arbiter: RTL and testbench

//  Shares the single 16-bit memory port between the instruction cache line fill and the

---
 rtl/memory_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_memory_port_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// Arbitrates the single memory port between 4-beat icache line fills and single-beat data accesses.
// Round-robin on contention; fills are uninterruptible; every beat stalls while mem_wt_i is high.
module memory_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ic_req_i,
    input  logic [ADDR_W-1:0]           ic_addr_i,
    output logic [DATA_W*BURST_LEN-1:0] ic_line_o,
    output logic                        ic_done_o,
    input  logic                        d_req_i,
    input  logic                        d_we_i,
    input  logic [ADDR_W-1:0]           d_addr_i,
    input  logic [DATA_W-1:0]           d_wdata_i,
    output logic [DATA_W-1:0]           d_rdata_o,
    output logic                        d_done_o,
    output logic [ADDR_W-1:0]           mem_addr_o,
    output logic [DATA_W-1:0]           mem_wdata_o,
    output logic                        mem_we_o,
    input  logic [DATA_W-1:0]           mem_rdata_i,
    input  logic                        mem_wt_i
);

    localparam int LINE_W = DATA_W * BURST_LEN;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic LG_DATA = 1'b0;
    localparam logic LG_IC   = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_IC   = 2'd1,
        S_D    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                last_grant_q, last_grant_d;
    logic [LINE_W-1:0]   ic_line_q, ic_line_d;
    logic                ic_done_q, ic_done_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                d_done_q, d_done_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;

    logic grant_ic, grant_d, done_busy;

    // A done pulse blocks arbitration for one cycle so the finishing requester can drop its request.
    assign done_busy = ic_done_q | d_done_q;
    assign grant_ic  = (state_q == S_IDLE) && !done_busy && ic_req_i &&
                       (!d_req_i || (last_grant_q == LG_DATA));
    assign grant_d   = (state_q == S_IDLE) && !done_busy && d_req_i &&
                       (!ic_req_i || (last_grant_q == LG_IC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_ic) begin
                    state_d = S_IC;
                end else if (grant_d) begin
                    state_d = S_D;
                end
            end
            S_IC: begin
                if (!mem_wt_i && (beat_q == LAST_BEAT)) begin
                    state_d = S_IDLE;
                end
            end
            S_D: begin
                if (!mem_wt_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        beat_d       = beat_q;
        last_grant_d = last_grant_q;
        ic_line_d    = ic_line_q;
        ic_done_d    = 1'b0;
        d_rdata_d    = d_rdata_q;
        d_done_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = mem_we_q;
        case (state_q)
            S_IDLE: begin
                if (grant_ic) begin
                    mem_addr_d   = ic_addr_i;
                    mem_we_d     = 1'b0;
                    beat_d       = '0;
                    last_grant_d = LG_IC;
                end else if (grant_d) begin
                    mem_addr_d   = d_addr_i;
                    mem_we_d     = d_we_i;
                    mem_wdata_d  = d_wdata_i;
                    last_grant_d = LG_DATA;
                end
            end
            S_IC: begin
                if (!mem_wt_i) begin
                    ic_line_d[DATA_W*beat_q +: DATA_W] = mem_rdata_i;
                    if (beat_q == LAST_BEAT) begin
                        ic_done_d = 1'b1;
                        beat_d    = '0;
                    end else begin
                        beat_d     = beat_q + 1'b1;
                        mem_addr_d = ic_addr_i + ADDR_W'(beat_q) + ADDR_W'(1);
                    end
                end
            end
            S_D: begin
                // The latched write enable decides read vs write; d_we_i may already have moved on.
                if (!mem_wt_i) begin
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata_i;
                    end
                    d_done_d = 1'b1;
                    mem_we_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q       <= '0;
            last_grant_q <= LG_DATA;
            ic_line_q    <= '0;
            ic_done_q    <= 1'b0;
            d_rdata_q    <= '0;
            d_done_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
        end else begin
            beat_q       <= beat_d;
            last_grant_q <= last_grant_d;
            ic_line_q    <= ic_line_d;
            ic_done_q    <= ic_done_d;
            d_rdata_q    <= d_rdata_d;
            d_done_q     <= d_done_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign ic_line_o   = ic_line_q;
    assign ic_done_o   = ic_done_q;
    assign d_rdata_o   = d_rdata_q;
    assign d_done_o    = d_done_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_we_o    = mem_we_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter with a small memory model behind the port.
module tb_memory_port_arbiter;

    logic        clk;
    logic        rst;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic [63:0] ic_line;
    logic        ic_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_done;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        mem_wt;

    int n_cmp = 0;
    int n_err = 0;

    // Memory reads back the address low half unless that address was written.
    logic        wr_vld = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [15:0] wr_data = '0;

    always_comb begin
        mem_rdata = mem_addr[15:0];
        if (wr_vld && (mem_addr == wr_addr)) begin
            mem_rdata = wr_data;
        end
    end

    always @(posedge clk) begin
        if (mem_we && !mem_wt) begin
            wr_vld  <= 1'b1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
        end
    end

    memory_port_arbiter #(.ADDR_W(32), .DATA_W(16), .BURST_LEN(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ic_req_i   (ic_req),
        .ic_addr_i  (ic_addr),
        .ic_line_o  (ic_line),
        .ic_done_o  (ic_done),
        .d_req_i    (d_req),
        .d_we_i     (d_we),
        .d_addr_i   (d_addr),
        .d_wdata_i  (d_wdata),
        .d_rdata_o  (d_rdata),
        .d_done_o   (d_done),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_we_o   (mem_we),
        .mem_rdata_i(mem_rdata),
        .mem_wt_i   (mem_wt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; ic_req = 1'b0; ic_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_wt = 1'b0;
        tick();
        chk("rst_mem_addr", 64'(mem_addr), 64'h0);
        chk("rst_ic_line", ic_line, 64'h0);
        chk("rst_dones", {62'h0, ic_done, d_done}, 64'h0);
        rst = 1'b0;
        tick();
        chk("idle_mem_we", 64'(mem_we), 64'h0);

        // 1: plain 4-beat fill
        ic_req = 1'b1; ic_addr = 32'h100;
        tick(); chk("t1_b0", 64'(mem_addr), 64'h100);
        tick(); chk("t1_b1", 64'(mem_addr), 64'h101);
        tick(); chk("t1_b2", 64'(mem_addr), 64'h102);
        tick(); chk("t1_b3", 64'(mem_addr), 64'h103);
        chk("t1_done_early", 64'(ic_done), 64'h0);
        tick(); chk("t1_done", 64'(ic_done), 64'h1);
        chk("t1_line", ic_line, 64'h0103_0102_0101_0100);
        ic_req = 1'b0;
        tick(); chk("t1_done_pulse", 64'(ic_done), 64'h0);
        chk("t1_line_hold", ic_line, 64'h0103_0102_0101_0100);

        // 2: write then read back
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 16'hBEEF;
        tick(); chk("t2_we", 64'(mem_we), 64'h1);
        chk("t2_addr", 64'(mem_addr), 64'h2000);
        chk("t2_wdata", 64'(mem_wdata), 64'hBEEF);
        tick(); chk("t2_wdone", 64'(d_done), 64'h1);
        chk("t2_we_off", 64'(mem_we), 64'h0);
        d_req = 1'b0;
        tick(); chk("t2_wdone_pulse", 64'(d_done), 64'h0);
        d_req = 1'b1; d_we = 1'b0;
        tick(); chk("t2_rd_we", 64'(mem_we), 64'h0);
        chk("t2_rd_addr", 64'(mem_addr), 64'h2000);
        tick(); chk("t2_rdone", 64'(d_done), 64'h1);
        chk("t2_rdata", 64'(d_rdata), 64'hBEEF);
        d_req = 1'b0;
        tick();

        // 3: simultaneous requests after reset, held: IC, DATA, IC
        rst = 1'b1; tick(); rst = 1'b0;
        ic_req = 1'b1; ic_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
        tick(); chk("t3_ic_first", 64'(mem_addr), 64'h200);
        tick(); tick(); tick(); chk("t3_ic_b3", 64'(mem_addr), 64'h203);
        tick(); chk("t3_ic_done", 64'(ic_done), 64'h1);
        chk("t3_no_ddone", 64'(d_done), 64'h0);
        tick(); chk("t3_gap_addr", 64'(mem_addr), 64'h203);
        tick(); chk("t3_data_second", 64'(mem_addr), 64'h3000);
        tick(); chk("t3_ddone", 64'(d_done), 64'h1);
        chk("t3_rdata", 64'(d_rdata), 64'h3000);
        chk("t3_no_icdone", 64'(ic_done), 64'h0);
        tick(); chk("t3_gap2_addr", 64'(mem_addr), 64'h3000);
        tick(); chk("t3_ic_third", 64'(mem_addr), 64'h200);
        d_req = 1'b0;
        tick(); tick(); tick(); tick(); chk("t3_ic2_done", 64'(ic_done), 64'h1);
        ic_req = 1'b0;
        tick();

        // 4: data request arrives mid-burst
        ic_req = 1'b1; ic_addr = 32'h400;
        tick(); chk("t4_b0", 64'(mem_addr), 64'h400);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        tick(); chk("t4_b1", 64'(mem_addr), 64'h401);
        tick(); chk("t4_b2", 64'(mem_addr), 64'h402);
        tick(); chk("t4_b3", 64'(mem_addr), 64'h403);
        tick(); chk("t4_done", 64'(ic_done), 64'h1);
        chk("t4_line", ic_line, 64'h0403_0402_0401_0400);
        ic_req = 1'b0;
        tick(); tick(); chk("t4_d_addr", 64'(mem_addr), 64'h500);
        tick(); chk("t4_ddone", 64'(d_done), 64'h1);
        chk("t4_rdata", 64'(d_rdata), 64'h0500);
        d_req = 1'b0;
        tick();

        // 5: three wait cycles on beat 2
        ic_req = 1'b1; ic_addr = 32'h600;
        tick(); tick(); tick(); chk("t5_b2", 64'(mem_addr), 64'h602);
        mem_wt = 1'b1;
        tick(); chk("t5_wait1", 64'(mem_addr), 64'h602);
        tick(); tick(); chk("t5_wait3", 64'(mem_addr), 64'h602);
        mem_wt = 1'b0;
        tick(); chk("t5_b3", 64'(mem_addr), 64'h603);
        chk("t5_not_done", 64'(ic_done), 64'h0);
        tick(); chk("t5_done", 64'(ic_done), 64'h1);
        chk("t5_line", ic_line, 64'h0603_0602_0601_0600);
        ic_req = 1'b0;
        tick();

        // 6: async reset mid-burst, then fresh fill
        ic_req = 1'b1; ic_addr = 32'h700;
        tick(); tick(); tick(); chk("t6_b2", 64'(mem_addr), 64'h702);
        #2 rst = 1'b1;
        #1 chk("t6_async_addr", 64'(mem_addr), 64'h0);
        chk("t6_async_line", ic_line, 64'h0);
        chk("t6_async_rdata", 64'(d_rdata), 64'h0);
        tick(); chk("t6_no_done", 64'(ic_done), 64'h0);
        rst = 1'b0;
        tick(); chk("t6_b0", 64'(mem_addr), 64'h700);
        tick(); tick(); tick(); chk("t6_b3", 64'(mem_addr), 64'h703);
        tick(); chk("t6_done", 64'(ic_done), 64'h1);
        chk("t6_line", ic_line, 64'h0703_0702_0701_0700);
        ic_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
